// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one 16-bit SRAM between the fetch and load/store ports.
// Each 32-bit access runs as two HOLD-cycle half-word phases (LO then HI), then a one-cycle DONE.
module sram_arbiter #(
  parameter int ADDR_W = 18,
  parameter int HOLD   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  output logic              if_stall,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_ready,
  output logic              mem_stall,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_dq_oe,
  output logic              sram_we_n,
  output logic              sram_oe_n
);
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic              last_cnt, mem_req, grant, grant_mem, active;
  logic              port_mem_reg, write_reg, last_mem_reg;
  logic              if_ready_reg, mem_ready_reg;
  logic [ADDR_W-2:0] addr_reg;
  logic [31:0]       wdata_reg, if_rdata_reg, mem_rdata_reg;
  logic [15:0]       lo_reg;
  logic              unused_addr_bits;

  assign mem_req   = mem_r_en | mem_w_en;
  assign last_cnt  = (cnt_reg == CW'(HOLD - 1));
  // On contention the port that did not win last time is served.
  assign grant_mem = mem_req & (~if_req | ~last_mem_reg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    grant      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (if_req | mem_req) begin
          grant      = 1'b1;
          state_next = LO;
          cnt_next   = '0;
        end
      end
      LO: begin
        if (last_cnt) begin
          state_next = HI;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      HI: begin
        if (last_cnt) begin
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      port_mem_reg  <= 1'b0;
      write_reg     <= 1'b0;
      last_mem_reg  <= 1'b1;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      lo_reg        <= '0;
      if_ready_reg  <= 1'b0;
      mem_ready_reg <= 1'b0;
      if_rdata_reg  <= '0;
      mem_rdata_reg <= '0;
    end else begin
      if_ready_reg  <= 1'b0;
      mem_ready_reg <= 1'b0;
      if (grant) begin
        port_mem_reg <= grant_mem;
        write_reg    <= grant_mem & mem_w_en;
        last_mem_reg <= grant_mem;
        addr_reg     <= grant_mem ? mem_addr[ADDR_W:2] : if_addr[ADDR_W:2];
        wdata_reg    <= mem_wdata;
      end
      if (state_reg == LO && last_cnt && !write_reg)
        lo_reg <= sram_dq_in;
      // Last HI cycle: assemble the read word and arm the one-cycle ready for DONE.
      if (state_reg == HI && last_cnt) begin
        if (port_mem_reg) mem_ready_reg <= 1'b1;
        else              if_ready_reg  <= 1'b1;
        if (!write_reg) begin
          if (port_mem_reg) mem_rdata_reg <= {sram_dq_in, lo_reg};
          else              if_rdata_reg  <= {sram_dq_in, lo_reg};
        end
      end
    end
  end

  assign active      = (state_reg == LO) || (state_reg == HI);
  assign sram_addr   = {addr_reg, state_reg == HI};
  assign sram_dq_out = (state_reg == HI) ? wdata_reg[31:16] : wdata_reg[15:0];
  assign sram_dq_oe  = active & write_reg;
  assign sram_we_n   = ~(active & write_reg);
  assign sram_oe_n   = ~(active & ~write_reg);

  assign if_ready  = if_ready_reg;
  assign mem_ready = mem_ready_reg;
  assign if_rdata  = if_rdata_reg;
  assign mem_rdata = mem_rdata_reg;
  assign if_stall  = if_req & ~if_ready_reg;
  assign mem_stall = mem_req & ~mem_ready_reg;

  assign unused_addr_bits = ^{if_addr[31:ADDR_W+1], if_addr[1:0],
                              mem_addr[31:ADDR_W+1], mem_addr[1:0]};
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: transaction-level model checked every cycle, directed pins,
// then randomized request traffic with occasional resets.
module tb_sram_arbiter;
  localparam int AW = 18;
  localparam int H  = 2;
  localparam int DK = 2 * H + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0, mem_r_en = 1'b0, mem_w_en = 1'b0;
  logic [31:0]   if_addr = '0, mem_addr = '0, mem_wdata = '0;
  logic [31:0]   if_rdata, mem_rdata;
  logic          if_ready, if_stall, mem_ready, mem_stall;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out, sram_dq_in;
  logic          sram_dq_oe, sram_we_n, sram_oe_n;

  logic [15:0] rom [256];
  assign sram_dq_in = rom[sram_addr[7:0]];

  sram_arbiter #(.ADDR_W(AW), .HOLD(H)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_ready(if_ready), .if_stall(if_stall),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .mem_stall(mem_stall),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_k counts cycles since the grant edge (0 = idle); 1..H LO, H+1..2H HI, DK DONE.
  int              m_k = 0;
  bit              m_mem, m_wr, m_last_mem = 1'b1;
  logic [AW-2:0]   m_addr;
  logic [31:0]     m_wd, m_if_rd = '0, m_mem_rd = '0;

  initial begin
    bit act, ph, done, e_if_rdy, e_mem_rdy;
    logic [AW-1:0] sa_lo, sa_hi;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_k = 0; m_last_mem = 1'b1; m_if_rd = '0; m_mem_rd = '0;
        e_if_rdy = 1'b0; e_mem_rdy = 1'b0;
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
        chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_dq_out", 32'(sram_dq_out), 32'd0);
        chk("rst_ready", {30'd0, if_ready, mem_ready}, 32'd0);
      end else begin
        act  = (m_k >= 1) && (m_k <= 2 * H);
        ph   = (m_k > H);
        done = (m_k == DK);
        e_if_rdy  = done && !m_mem;
        e_mem_rdy = done && m_mem;
        if (done && !m_wr) begin
          sa_lo = {m_addr, 1'b0};
          sa_hi = {m_addr, 1'b1};
          if (m_mem) m_mem_rd = {rom[sa_hi[7:0]], rom[sa_lo[7:0]]};
          else       m_if_rd  = {rom[sa_hi[7:0]], rom[sa_lo[7:0]]};
        end
        chk("we_n", 32'(sram_we_n), 32'(!(act && m_wr)));
        chk("oe_n", 32'(sram_oe_n), 32'(!(act && !m_wr)));
        chk("dq_oe", 32'(sram_dq_oe), 32'(act && m_wr));
        chk("if_ready", 32'(if_ready), 32'(e_if_rdy));
        chk("mem_ready", 32'(mem_ready), 32'(e_mem_rdy));
        if (act) begin
          chk("sram_addr", 32'(sram_addr), 32'({m_addr, ph}));
          if (m_wr) chk("dq_out", 32'(sram_dq_out), ph ? 32'(m_wd[31:16]) : 32'(m_wd[15:0]));
        end
      end
      chk("if_rdata", if_rdata, m_if_rd);
      chk("mem_rdata", mem_rdata, m_mem_rd);
      chk("if_stall", 32'(if_stall), 32'(if_req && !e_if_rdy));
      chk("mem_stall", 32'(mem_stall), 32'((mem_r_en || mem_w_en) && !e_mem_rdy));
      if (rst) begin
        if (m_k == DK) m_k = 0;
        else if (m_k > 0) m_k++;
        else if (if_req || mem_r_en || mem_w_en) begin
          m_mem      = (mem_r_en || mem_w_en) && !(if_req && m_last_mem);
          m_last_mem = m_mem;
          m_wr       = m_mem && mem_w_en;
          m_addr     = m_mem ? mem_addr[AW:2] : if_addr[AW:2];
          m_wd       = mem_wdata;
          m_k        = 1;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drop_all();
    if_req = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
  endtask

  task automatic do_reset();
    drop_all();
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
  endtask

  initial begin
    int ifc, memc;
    foreach (rom[i]) rom[i] = 16'($urandom);
    rom[4] = 16'h1111;
    rom[5] = 16'h2222;
    cyc(3);
    rst = 1'b1;

    // Fetch at 0x8: half-words 4 then 5, ready five cycles after the idle sample.
    if_req = 1'b1; if_addr = 32'h8;
    @(negedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        chk("t1_addr", 32'(sram_addr), (c <= 2) ? 32'd4 : 32'd5);
        chk("t1_oe_n", 32'(sram_oe_n), 32'd0);
        chk("t1_early_ready", 32'(if_ready), 32'd0);
      end else begin
        chk("t1_ready", 32'(if_ready), 32'd1);
        chk("t1_rdata", if_rdata, 32'h22221111);
      end
    end
    cyc(1); drop_all(); cyc(2);

    // Store 0xDEADBEEF at 0x10.
    mem_w_en = 1'b1; mem_addr = 32'h10; mem_wdata = 32'hDEADBEEF;
    @(negedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        chk("t2_we_n", 32'(sram_we_n), 32'd0);
        chk("t2_oe_n", 32'(sram_oe_n), 32'd1);
        chk("t2_addr", 32'(sram_addr), (c <= 2) ? 32'd8 : 32'd9);
        chk("t2_dq", 32'(sram_dq_out), (c <= 2) ? 32'hBEEF : 32'hDEAD);
      end else begin
        chk("t2_ready", {30'd0, if_ready, mem_ready}, 32'd1);
      end
    end
    cyc(1); drop_all(); cyc(2);

    // Simultaneous requests from reset: IF first, then MEM.
    do_reset();
    if_req = 1'b1; mem_r_en = 1'b1; if_addr = $urandom; mem_addr = $urandom;
    @(negedge clk);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c < 5) chk("t3_stalls", {30'd0, if_stall, mem_stall}, 32'd3);
      if (c == 5) begin
        chk("t3_if_first", {30'd0, if_ready, mem_ready}, 32'd2);
        chk("t3_mem_stall", 32'(mem_stall), 32'd1);
        @(posedge clk); #1; if_req = 1'b0;
      end
      if (c == 11) chk("t3_mem_next", {30'd0, if_ready, mem_ready}, 32'd1);
    end
    cyc(1); drop_all(); cyc(2);

    // Both held for eight accesses: strict alternation starting with IF.
    do_reset();
    if_req = 1'b1; mem_r_en = 1'b1; if_addr = $urandom; mem_addr = $urandom;
    ifc = 0; memc = 0;
    @(negedge clk);
    for (int c = 1; c <= 48; c++) begin
      @(negedge clk);
      ifc  += int'(if_ready);
      memc += int'(mem_ready);
      if ((c - 5) % 6 == 0 && c >= 5)
        chk("t4_port", {30'd0, if_ready, mem_ready}, (((c - 5) / 6) % 2 == 0) ? 32'd2 : 32'd1);
    end
    chk("t4_if_count", 32'(ifc), 32'd4);
    chk("t4_mem_count", 32'(memc), 32'd4);
    cyc(1); drop_all(); cyc(2);

    // Reset during the HI phase of a store.
    do_reset();
    mem_w_en = 1'b1; mem_addr = 32'h20; mem_wdata = $urandom;
    @(negedge clk);
    for (int c = 1; c <= 3; c++) @(negedge clk);
    chk("t5_in_hi", 32'(sram_we_n), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("t5_we_n", 32'(sram_we_n), 32'd1);
    chk("t5_dq_oe", 32'(sram_dq_oe), 32'd0);
    drop_all();
    cyc(2);
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("t5_no_ready", {30'd0, if_ready, mem_ready}, 32'd0);
    end
    cyc(1);

    // Read and write enables together: the store wins, load data untouched.
    do_reset();
    mem_r_en = 1'b1; mem_w_en = 1'b1; mem_addr = 32'h40; mem_wdata = 32'h12345678;
    @(negedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) chk("t6_we_oe", {30'd0, sram_we_n, sram_oe_n}, 32'd1);
      if (c == 5) begin
        chk("t6_ready", 32'(mem_ready), 32'd1);
        chk("t6_rdata", mem_rdata, 32'd0);
      end
    end
    cyc(1); drop_all(); cyc(2);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) begin if_req = $urandom_range(1); if_addr = $urandom; end
      if ($urandom_range(3) == 0) begin
        mem_r_en = $urandom_range(1); mem_w_en = ($urandom_range(2) == 0);
        mem_addr = $urandom; mem_wdata = $urandom;
      end
      rst = ($urandom_range(250) != 0);
      cyc(1);
    end
    rst = 1'b1;
    drop_all();
    cyc(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
